// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: stage record layout and
// the EX operand-mux select encoding.
package hazard_pkg;
  // rd is stored at a fixed width so the record type is parameter-independent;
  // REG_AW must not exceed RD_W.
  localparam int RD_W = 8;
  typedef logic [RD_W-1:0] rd_t;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

  typedef struct packed {
    logic valid;
    rd_t  rd;
    logic reg_write;
    logic mem_read;
  } stage_rec_t;
endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage record: holds when en_i=0, loads a bubble when clr_i=1.
import hazard_pkg::*;

module hazard_stage_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       clr_i,
  input  stage_rec_t d_i,
  output stage_rec_t q_o
);
  stage_rec_t rec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rec_q <= '0;
    else if (en_i) rec_q <= clr_i ? '0 : d_i;
  end

  assign q_o = rec_q;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall / bubble generation and registered EX operand forwarding
// selects for a 5-stage in-order pipe.
import hazard_pkg::*;

module hazard_fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              mem_busy,
  input  logic              flush,
  output logic              stall_f,
  output logic              bubble_e,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_count
);
  stage_rec_t id_rec, ex_q, mem_q, wb_q;
  logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
  logic load_use, kill_ex, adv;
  fwd_sel_t fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  function automatic logic prod_match(stage_rec_t r, logic [REG_AW-1:0] src, logic used);
    return used && r.valid && r.reg_write && (r.rd == rd_t'(src)) && (r.rd != '0);
  endfunction

  // Youngest producer wins; a WB producer is already visible through the
  // regfile (write-before-read), so it resolves to the regfile path.
  function automatic fwd_sel_t pick(logic ex_m, logic mem_m, logic wb_m);
    if (ex_m)  return FWD_MEM;
    if (mem_m) return FWD_WB;
    if (wb_m)  return FWD_RF;
    return FWD_RF;
  endfunction

  always_comb begin
    id_rec           = '0;
    id_rec.valid     = id_valid;
    id_rec.rd        = rd_t'(id_rd);
    id_rec.reg_write = id_reg_write;
    id_rec.mem_read  = id_mem_read;
  end

  assign ex_a  = prod_match(ex_q,  id_rs, id_rs_used);
  assign ex_b  = prod_match(ex_q,  id_rt, id_rt_used);
  assign mem_a = prod_match(mem_q, id_rs, id_rs_used);
  assign mem_b = prod_match(mem_q, id_rt, id_rt_used);
  assign wb_a  = prod_match(wb_q,  id_rs, id_rs_used);
  assign wb_b  = prod_match(wb_q,  id_rt, id_rt_used);

  assign load_use = id_valid && ex_q.mem_read && (ex_a || ex_b);
  assign kill_ex  = load_use || flush;
  assign adv      = !mem_busy;

  // mem_busy freezes everything and masks flush; flush overrides load-use stall.
  assign stall_f  = rst_n && (mem_busy || (load_use && !flush));
  assign bubble_e = rst_n && !mem_busy && kill_ex;

  hazard_stage_reg u_ex  (.clk(clk), .rst_n(rst_n), .en_i(adv), .clr_i(kill_ex), .d_i(id_rec), .q_o(ex_q));
  hazard_stage_reg u_mem (.clk(clk), .rst_n(rst_n), .en_i(adv), .clr_i(1'b0),    .d_i(ex_q),   .q_o(mem_q));
  hazard_stage_reg u_wb  (.clk(clk), .rst_n(rst_n), .en_i(adv), .clr_i(1'b0),    .d_i(mem_q),  .q_o(wb_q));

  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (adv) begin
      fwd_a_d = kill_ex ? FWD_RF : pick(ex_a, mem_a, wb_a);
      fwd_b_d = kill_ex ? FWD_RF : pick(ex_b, mem_b, wb_b);
    end
    stall_cnt_d = (stall_f && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
    end else begin
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign stall_count = stall_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed cycle table, hand corner sequences, then
// random traffic against an in-flight-instruction reference model.
module tb_hazard_fwd_ctrl;
  localparam int AW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read, mem_busy, flush;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic stall_f, bubble_e;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_count;

  int n_chk = 0;
  int n_pass = 0;

  hazard_fwd_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .mem_busy(mem_busy),
    .flush(flush), .stall_f(stall_f), .bubble_e(bubble_e), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit idv; int rs; int rt; bit rsu; bit rtu; int rd; bit rw; bit mr; bit busy; bit fl;
    bit e_st; bit e_bu; int e_a; int e_b; int e_cnt;
  } vec_t;
  vec_t tbl[16];

  // Reference model: instructions that have left ID, index 0 = one stage past ID.
  typedef struct { bit v; int rd; bit rw; bit mr; } ins_t;
  ins_t pipe[3];
  int m_a, m_b, m_cnt;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int rs, int rt, bit ru, bit tu, int rd, bit rw, bit mr, bit bz, bit fl);
    id_valid = v; id_rs = rs[AW-1:0]; id_rt = rt[AW-1:0]; id_rs_used = ru; id_rt_used = tu;
    id_rd = rd[AW-1:0]; id_reg_write = rw; id_mem_read = mr; mem_busy = bz; flush = fl;
  endtask

  // Distance to the youngest in-flight producer of src: 1 -> 01, 2 -> 10, else 00.
  function automatic int m_sel(int src, bit used);
    for (int d = 0; d < 2; d++)
      if (used && src != 0 && pipe[d].v && pipe[d].rw && pipe[d].rd == src) return d + 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    m_a = 0; m_b = 0; m_cnt = 0;
  endtask

  task automatic model_check_and_step(string tag);
    int sa, sb;
    bit lu, st, bu;
    sa = m_sel(int'(id_rs), id_rs_used);
    sb = m_sel(int'(id_rt), id_rt_used);
    lu = id_valid && pipe[0].mr && (sa == 1 || sb == 1);
    st = mem_busy || (lu && !flush);
    bu = !mem_busy && (lu || flush);
    chk({tag, "_stall"}, stall_f, st);
    chk({tag, "_bubble"}, bubble_e, bu);
    chk({tag, "_fwd_a"}, fwd_a_sel, m_a);
    chk({tag, "_fwd_b"}, fwd_b_sel, m_b);
    chk({tag, "_cnt"}, stall_count, m_cnt);
    if (st && m_cnt < (1 << CW) - 1) m_cnt++;
    if (!mem_busy) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (lu || flush) begin
        pipe[0] = '{0, 0, 0, 0}; m_a = 0; m_b = 0;
      end else begin
        pipe[0] = '{id_valid, int'(id_rd), id_reg_write, id_mem_read}; m_a = sa; m_b = sb;
      end
    end
  endtask

  initial begin
    // idv rs rt rsu rtu rd rw mr busy fl | stall bubble a b cnt
    tbl[0]  = '{1,1,2,1,1,3,1,0,0,0, 0,0,0,0,0};  // add r3
    tbl[1]  = '{1,3,1,1,1,4,1,0,0,0, 0,0,0,0,0};  // sub reads r3
    tbl[2]  = '{1,3,6,1,1,5,1,0,0,0, 0,0,1,0,0};  // sub in EX: a=01
    tbl[3]  = '{0,0,0,0,0,0,0,0,0,0, 0,0,2,0,0};  // reader of r3 with add in WB: a=10
    tbl[4]  = '{1,1,0,1,0,5,1,1,0,0, 0,0,0,0,0};  // lw r5
    tbl[5]  = '{1,5,1,1,1,6,1,0,0,0, 1,1,0,0,0};  // add r6,r5,r1: load-use
    tbl[6]  = '{1,5,1,1,1,6,1,0,0,0, 0,0,0,0,1};  // retry after bubble
    tbl[7]  = '{0,0,0,0,0,0,0,0,0,0, 0,0,2,0,1};  // forwarded from WB
    tbl[8]  = '{1,1,2,1,1,0,1,0,0,0, 0,0,0,0,1};  // writes r0
    tbl[9]  = '{1,1,0,1,0,0,1,1,0,0, 0,0,0,0,1};  // lw r0
    tbl[10] = '{1,0,0,1,1,8,1,0,0,0, 0,0,0,0,1};  // reads r0 twice: no stall
    tbl[11] = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1};
    tbl[12] = '{1,1,2,1,1,7,1,0,0,0, 0,0,0,0,1};  // writes r7
    tbl[13] = '{1,1,2,1,1,7,1,0,0,0, 0,0,0,0,1};  // writes r7 again
    tbl[14] = '{1,1,7,1,1,9,1,0,0,0, 0,0,0,0,1};  // reads r7 on rt
    tbl[15] = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,1,1};  // youngest r7 wins: b=01

    rst_n = 1'b0;
    drive(1, 5, 5, 1, 1, 5, 1, 1, 1, 1);
    tick(); tick();
    @(negedge clk);
    chk("rst_stall", stall_f, 0);
    chk("rst_bubble", bubble_e, 0);
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_fwd_b", fwd_b_sel, 0);
    chk("rst_cnt", stall_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].idv, tbl[i].rs, tbl[i].rt, tbl[i].rsu, tbl[i].rtu, tbl[i].rd,
            tbl[i].rw, tbl[i].mr, tbl[i].busy, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), stall_f, tbl[i].e_st);
      chk($sformatf("tbl%0d_bubble", i), bubble_e, tbl[i].e_bu);
      chk($sformatf("tbl%0d_fwd_a", i), fwd_a_sel, tbl[i].e_a);
      chk($sformatf("tbl%0d_fwd_b", i), fwd_b_sel, tbl[i].e_b);
      chk($sformatf("tbl%0d_cnt", i), stall_count, tbl[i].e_cnt);
      tick();
    end

    // mem_busy freeze with a flush pulse that is dropped before release.
    drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0); tick();       // add r3
    drive(1, 3, 4, 1, 1, 10, 1, 0, 0, 0); tick();      // reads r3 -> sel_a 01
    for (int c = 0; c < 3; c++) begin
      drive(1, 10, 3, 1, 1, 11, 1, 0, 1, c == 1);
      @(negedge clk);
      chk($sformatf("busy%0d_stall", c), stall_f, 1);
      chk($sformatf("busy%0d_bubble", c), bubble_e, 0);
      chk($sformatf("busy%0d_fwd_a", c), fwd_a_sel, 1);
      chk($sformatf("busy%0d_fwd_b", c), fwd_b_sel, 0);
      chk($sformatf("busy%0d_cnt", c), stall_count, 1 + c);
      tick();
    end
    drive(1, 10, 3, 1, 1, 11, 1, 0, 0, 0);
    @(negedge clk);
    chk("rel_stall", stall_f, 0);
    chk("rel_bubble", bubble_e, 0);
    tick();
    // held records: EX producer r10 -> 01, MEM still add r3 -> 10
    drive(1, 1, 2, 1, 1, 12, 1, 0, 1, 1);
    @(negedge clk);
    chk("held_fwd_a", fwd_a_sel, 1);
    chk("held_fwd_b", fwd_b_sel, 2);
    chk("held_cnt", stall_count, 4);
    tick();
    drive(1, 1, 2, 1, 1, 12, 1, 0, 0, 1);              // flush held past release
    @(negedge clk);
    chk("flush_stall", stall_f, 0);
    chk("flush_bubble", bubble_e, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_fwd_a", fwd_a_sel, 0);
    chk("flush_fwd_b", fwd_b_sel, 0);

    // Counter saturation, then reset asserted mid-stall.
    force dut.stall_cnt_q = 16'hFFFE;
    #1 release dut.stall_cnt_q;
    chk("sat_preset", stall_count, 16'hFFFE);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1, 5, 5, 1, 1, 6, 1, 0, 1, 0);
      @(negedge clk);
      chk($sformatf("sat%0d_cnt", c), stall_count, c == 0 ? 16'hFFFE : 16'hFFFF);
      if (c < 2) tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_stall", stall_f, 0);
    chk("midrst_bubble", bubble_e, 0);
    chk("midrst_fwd_a", fwd_a_sel, 0);
    chk("midrst_fwd_b", fwd_b_sel, 0);
    chk("midrst_cnt", stall_count, 0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(9, 0) < 8, $urandom_range(7, 0), $urandom_range(7, 0),
            $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(7, 0),
            $urandom_range(1, 0), $urandom_range(9, 0) < 3,
            $urandom_range(19, 0) < 3, $urandom_range(9, 0) == 0);
      @(negedge clk);
      model_check_and_step("rnd");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
